tone_generator: RTL and testbench

TONE_GENERATOR -- requirements
Module: tone_generator

---
 rtl/tone_generator.sv | 171 +++++++++++++++++
 tb/tb_tone_generator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_generator.sv
// ----------------------------------------------------------------------------
// tone_generator
//   Square-wave note generator (C5..C6) with a ~48 kHz sample stream behind a
//   one-deep valid/ready output buffer.
//
//   Ports
//     CLOCK_50      in   1   sole clock, rising edge
//     RESET_N       in   1   asynchronous active-low reset
//     note_sel      in   3   note index 0..7 (switches, asynchronous)
//     tone_en       in   1   tone enable (switch, asynchronous)
//     sq_out        out  1   raw square wave at the note frequency
//     sample        out  16  signed audio sample
//     sample_valid  out  1   sample holds a word not yet accepted
//     sample_ready  in   1   downstream accepts a word this cycle
//     overrun       out  1   sticky: a sample tick was dropped
//     note_led      out  8   one-hot active note, 0 while disabled
// ----------------------------------------------------------------------------
module tone_generator #(
    parameter int unsigned        SAMPLE_DIV = 1042,
    parameter logic signed [15:0] AMPLITUDE  = 16'sd8192
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic [2:0]         note_sel,
    input  logic               tone_en,
    output logic               sq_out,
    output logic signed [15:0] sample,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               overrun,
    output logic [7:0]         note_led
);

    localparam logic [10:0] DIV_LAST = 11'(SAMPLE_DIV - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

    // Half-period lengths in CLOCK_50 cycles, C5..C6.
    function automatic logic [15:0] half_period(input logic [2:0] note);
        case (note)
            3'd0:    half_period = 16'd47801;
            3'd1:    half_period = 16'd42589;
            3'd2:    half_period = 16'd37936;
            3'd3:    half_period = 16'd35816;
            3'd4:    half_period = 16'd31928;
            3'd5:    half_period = 16'd28409;
            3'd6:    half_period = 16'd25329;
            default: half_period = 16'd23900;
        endcase
    endfunction

    function automatic logic signed [15:0] sample_for(input logic en, input logic level);
        if (!en)
            sample_for = 16'sd0;
        else if (level)
            sample_for = AMPLITUDE;
        else
            sample_for = -AMPLITUDE;
    endfunction

    logic [2:0]         note_s1_q, note_s2_q;
    logic               en_s1_q, en_s2_q;
    logic [15:0]        half_cnt_q, half_cnt_d;
    logic               sq_q, sq_d;
    logic [10:0]        div_q, div_d;
    buf_state_t         state_q, state_d;
    logic signed [15:0] sample_q, sample_d;
    logic               overrun_q, overrun_d;

    logic               tick;
    logic               xfer;
    logic               note_chg;
    logic [15:0]        hp_last;

    // Two-flop synchronizers; the second stage is the active value.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            note_s1_q <= 3'd0;
            note_s2_q <= 3'd0;
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
        end else begin
            note_s1_q <= note_sel;
            note_s2_q <= note_s1_q;
            en_s1_q   <= tone_en;
            en_s2_q   <= en_s1_q;
        end
    end

    // The active note is about to change when the two stages disagree, so the
    // counter clears on the same edge the new note becomes active and the new
    // note gets a full first half-period.
    assign note_chg = (note_s1_q != note_s2_q);
    assign hp_last  = half_period(note_s2_q) - 16'd1;

    always_comb begin
        half_cnt_d = half_cnt_q;
        sq_d       = sq_q;
        if (!en_s2_q) begin
            half_cnt_d = 16'd0;
            sq_d       = 1'b0;
        end else if (note_chg) begin
            half_cnt_d = 16'd0;
        end else if (half_cnt_q == hp_last) begin
            half_cnt_d = 16'd0;
            sq_d       = ~sq_q;
        end else begin
            half_cnt_d = half_cnt_q + 16'd1;
        end
    end

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? 11'd0 : div_q + 11'd1;

    assign xfer = (state_q == FULL) && sample_ready;

    // Output buffer: state register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // Output buffer: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (tick) state_d = FULL;
            FULL:    if (xfer && !tick) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output buffer: outputs and held data. A tick is only accepted when the
    // slot is free or is being emptied in the same cycle; otherwise the held
    // word wins and the drop is recorded.
    always_comb begin
        sample_valid = (state_q == FULL);
        sample_d     = sample_q;
        overrun_d    = overrun_q;
        if (tick) begin
            if (state_q == EMPTY || xfer)
                sample_d = sample_for(en_s2_q, sq_q);
            else
                overrun_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            half_cnt_q <= 16'd0;
            sq_q       <= 1'b0;
            div_q      <= 11'd0;
            sample_q   <= 16'sd0;
            overrun_q  <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            sq_q       <= sq_d;
            div_q      <= div_d;
            sample_q   <= sample_d;
            overrun_q  <= overrun_d;
        end
    end

    assign sq_out   = sq_q;
    assign sample   = sample_q;
    assign overrun  = overrun_q;
    assign note_led = en_s2_q ? (8'b1 << note_s2_q) : 8'b0;

endmodule

// File: tb/tb_tone_generator.sv
module tb_tone_generator;

    localparam int DIV = 1042;
    localparam int AMP = 8192;

    logic               CLOCK_50 = 1'b0;
    logic               RESET_N  = 1'b0;
    logic [2:0]         note_sel = 3'd0;
    logic               tone_en  = 1'b0;
    logic               sample_ready = 1'b0;
    logic               sq_out;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               overrun;
    logic [7:0]         note_led;

    int total = 0;
    int bad   = 0;
    int rmode = 1;   // 0: ready low, 1: ready high, 2: ready only in tick cycles, 3: random

    tone_generator #(.SAMPLE_DIV(DIV), .AMPLITUDE(16'sd8192)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .note_sel    (note_sel),
        .tone_en     (tone_en),
        .sq_out      (sq_out),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun),
        .note_led    (note_led)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int hp_of(input int note);
        int tbl [8] = '{47801, 42589, 37936, 35816, 31928, 28409, 25329, 23900};
        return tbl[note];
    endfunction

    // ------------------------------------------------------------------
    // Reference model. n counts rising edges since RESET_N released.
    // Inputs become active two edges after being sampled. The square wave
    // is described by its last restart edge: it toggles exactly at
    // restart + k*half_period while the tone stays on and the note stays put.
    // Ticks fall on every edge n that is a multiple of DIV.
    // ------------------------------------------------------------------
    int m_n = 0, m_restart = 0, m_samp = 0;
    int h1n = 0, h2n = 0;
    bit h1e = 0, h2e = 0;
    bit m_sq = 0, m_full = 0, m_ovr = 0;

    initial begin
        bit tone_on, chg, xfer, tk;
        int tv;
        forever begin
            @(posedge CLOCK_50 or negedge RESET_N);
            if (!RESET_N) begin
                m_n = 0; m_restart = 0; m_samp = 0;
                h1n = 0; h2n = 0; h1e = 0; h2e = 0;
                m_sq = 0; m_full = 0; m_ovr = 0;
            end else begin
                tone_on = h2e;
                chg     = (h1n != h2n);
                xfer    = m_full && sample_ready;
                m_n++;
                tk = (m_n % DIV) == 0;
                tv = !tone_on ? 0 : (m_sq ? AMP : -AMP);
                if (!tone_on || chg)
                    m_restart = m_n;
                else if ((m_n - m_restart) % hp_of(h2n) == 0)
                    m_sq = !m_sq;
                if (!tone_on) m_sq = 0;
                if (tk) begin
                    if (!m_full || xfer) begin
                        m_samp = tv;
                        m_full = 1;
                    end else begin
                        m_ovr = 1;
                    end
                end else if (xfer) begin
                    m_full = 0;
                end
                h2n = h1n; h1n = int'(note_sel);
                h2e = h1e; h1e = tone_en;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        logic [26:0] act, exp;
        forever begin
            @(negedge CLOCK_50);
            if (RESET_N && bad < 30) begin
                act = {sq_out, sample_valid, overrun, note_led, sample};
                exp = {m_sq, m_full, m_ovr, (h2e ? 8'(1 << h2n) : 8'h00), 16'(m_samp)};
                total++;
                if (act !== exp) begin
                    bad++;
                    $display("FAIL cycle_%0d: got %0h expected %0h", m_n, act, exp);
                end
            end
        end
    end

    // Ready driver, changes only on the falling edge.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            case (rmode)
                0:       sample_ready = 1'b0;
                1:       sample_ready = 1'b1;
                2:       sample_ready = ((m_n + 1) % DIV) == 0;
                default: sample_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    typedef struct {
        logic [2:0] note;
        logic       en;
        logic [7:0] led;
    } vec_t;

    task automatic first_valid_after_release(input string name);
        int c = 0;
        while (c < 3 * DIV) begin
            @(posedge CLOCK_50);
            #1;
            c++;
            if (sample_valid) break;
        end
        chk(name, c, DIV);
    endtask

    initial begin
        vec_t vecs [8];
        int c, cnt;
        logic prev;

        vecs[0] = '{3'd3, 1'b1, 8'h08};
        vecs[1] = '{3'd5, 1'b0, 8'h00};
        vecs[2] = '{3'd7, 1'b1, 8'h80};
        vecs[3] = '{3'd0, 1'b1, 8'h01};
        vecs[4] = '{3'd6, 1'b1, 8'h40};
        vecs[5] = '{3'd1, 1'b1, 8'h02};
        vecs[6] = '{3'd4, 1'b1, 8'h10};
        vecs[7] = '{3'd2, 1'b0, 8'h00};

        // Reset state
        repeat (5) @(negedge CLOCK_50);
        chk("rst_sq", sq_out, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_sample", sample, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_led", note_led, 0);
        RESET_N = 1'b1;
        first_valid_after_release("first_tick_after_reset");

        // Table of note/enable settings against the LED view
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50);
            note_sel = vecs[i].note;
            tone_en  = vecs[i].en;
            repeat (3) @(negedge CLOCK_50);
            chk($sformatf("led_vec%0d", i), note_led, vecs[i].led);
        end

        // Note 0 from disabled; sample-stream scenarios run meanwhile
        @(negedge CLOCK_50);
        note_sel = 3'd0;
        tone_en  = 1'b1;
        rmode    = 2;
        fork
            begin
                c = 0;
                while (sq_out == 1'b0 && c < 50000) begin
                    @(posedge CLOCK_50);
                    #1;
                    c++;
                end
                // sampled on edge 1, active after edge 2, toggle 47801 edges later
                chk("note0_first_toggle", c, 47801 + 2);
            end
            begin
                repeat (DIV + 5) @(negedge CLOCK_50);
                cnt = 0;
                repeat (3 * DIV) begin
                    @(negedge CLOCK_50);
                    if (!sample_valid) cnt++;
                end
                chk("pulse_valid_never_drops", cnt, 0);
                chk("pulse_no_overrun", overrun, 0);
                rmode = 1;
                repeat (10) @(negedge CLOCK_50);
                cnt = 0;
                repeat (3 * DIV) begin
                    @(negedge CLOCK_50);
                    if (sample_valid) cnt++;
                end
                chk("one_valid_cycle_per_tick", cnt, 3);
                rmode = 0;
                repeat (3000) @(negedge CLOCK_50);
                chk("stall_overrun", overrun, 1);
                chk("stall_valid", sample_valid, 1);
                chk("stall_sample_frozen", 32'(sample), 32'(-16'sd8192));
                rmode = 3;
            end
        join
        chk("note0_led", note_led, 8'h01);

        // Mid-period change to note 7
        repeat (5000) @(negedge CLOCK_50);
        prev = sq_out;
        note_sel = 3'd7;
        c = 0;
        while (sq_out == prev && c < 30000) begin
            @(posedge CLOCK_50);
            #1;
            c++;
        end
        chk("note7_restart_toggle", c, 23900 + 2);
        chk("note7_led", note_led, 8'h80);

        // Random notes, enables and ready
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            note_sel = 3'($urandom_range(0, 7));
            tone_en  = 1'($urandom_range(0, 3) != 0);
            repeat ($urandom_range(20, 150)) @(negedge CLOCK_50);
        end

        // Tone disabled, handshake left pending, then reset mid-handshake
        @(negedge CLOCK_50);
        tone_en = 1'b0;
        rmode   = 0;
        repeat (2 * DIV + 10) @(negedge CLOCK_50);
        chk("off_valid", sample_valid, 1);
        chk("off_sample", sample, 0);
        chk("off_sq", sq_out, 0);
        chk("off_led", note_led, 0);
        chk("sticky_overrun", overrun, 1);
        @(negedge CLOCK_50);
        #3 RESET_N = 1'b0;
        #1;
        chk("async_rst_valid", sample_valid, 0);
        chk("async_rst_overrun", overrun, 0);
        chk("async_rst_sample", sample, 0);
        chk("async_rst_sq", sq_out, 0);
        chk("async_rst_led", note_led, 0);
        repeat (3) @(negedge CLOCK_50);
        rmode   = 1;
        RESET_N = 1'b1;
        first_valid_after_release("first_tick_after_rerelease");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
